// File: rtl/button_debouncer.sv
// Multi-channel two-flop synchronizer and counter-based debouncer with
// registered one-cycle rise/fall pulses per channel.
module button_debouncer #(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = 50000,
  parameter int INVERT        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_db,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int              CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH-1:0] INV_MASK = (INVERT != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] w_level;

  // Synchronizers reset to INVERT so the polarity-corrected level reads idle.
  assign w_level = r_sync2 ^ INV_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= INV_MASK;
      r_sync2 <= INV_MASK;
      r_db    <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < WIDTH; i++) begin
        r_rise[i] <= 1'b0;
        r_fall[i] <= 1'b0;
        // One cycle of agreement discards the qualification count.
        if (w_level[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_db[i]   <= w_level[i];
          r_cnt[i]  <= '0;
          r_rise[i] <= w_level[i];
          r_fall[i] <= ~w_level[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign btn_db = r_db;
  assign rise   = r_rise;
  assign fall   = r_fall;

endmodule
